// File: rtl/bram_stream_reader.sv
// Read-side sequencer for the simple synchronous dual-port BRAM: issues reads from
// base_addr, hides the one-cycle read latency and streams words out over valid/ready.
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_r,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     issued;
    logic [ADDR_WIDTH:0]     delivered;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   buf_head;
    logic [DATA_WIDTH-1:0]   buf_tail;
    logic [1:0]              buf_count;
    logic                    busy_q;
    logic                    accept_start;
    logic                    pop;
    logic                    issue;
    logic [2:0]              occupancy;

    assign addr_r    = rd_ptr;
    assign m_data    = buf_head;
    assign m_valid   = (buf_count != 2'd0);
    assign m_last    = m_valid & (delivered == (len_q - CNT_ONE));
    assign done      = (state == FINISH);
    assign busy      = busy_q;
    assign pop       = m_valid & m_ready;
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight};

    // Buffered plus in-flight words never exceed two, counting this cycle's pop as freed.
    assign issue = (state == READ) && (issued < len_q) &&
                   (occupancy < (pop ? 3'd3 : 3'd2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_nxt    = (length == '0) ? FINISH : READ;
                end
            end
            READ: begin
                if (pop && m_last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            len_q     <= '0;
            issued    <= '0;
            delivered <= '0;
            busy_q    <= 1'b0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept_start) begin
                rd_ptr    <= base_addr;
                len_q     <= length;
                issued    <= '0;
                delivered <= '0;
                busy_q    <= 1'b1;
            end else begin
                if (issue) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    issued <= issued + CNT_ONE;
                end
                if (pop) begin
                    delivered <= delivered + CNT_ONE;
                end
                if ((state == READ && pop && m_last) || state == FINISH) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    // Two-entry FIFO; on simultaneous capture and pop the new word lands behind the survivor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_head  <= '0;
            buf_tail  <= '0;
            buf_count <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (buf_count == 2'd0) begin
                        buf_head <= mem_dout;
                    end else begin
                        buf_tail <= mem_dout;
                    end
                    buf_count <= buf_count + 2'd1;
                end
                2'b01: begin
                    buf_head  <= buf_tail;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        buf_head <= mem_dout;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= mem_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
